// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch/sequencing unit:
// instruction-pointer load encodings, fetch states and opcode field position.
package instr_fetch_pkg;

  localparam int unsigned OPCODE_WIDTH = 8;

  typedef enum logic [1:0] {
    IPTR_INC       = 2'b00,
    IPTR_JUMP      = 2'b01,
    IPTR_JUMP_COND = 2'b10,
    IPTR_RSVD      = 2'b11
  } iptr_load_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } fetch_state_e;

  // Opcode occupies the top OPCODE_WIDTH bits of the instruction word.
  function automatic int unsigned opcode_msb(input int unsigned instr_width);
    return instr_width - 1;
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch/sequencing unit: owns the instruction pointer, reads the
// synchronous instruction memory and hands words to the decoder via valid/ready.
// Optional stall counter output enabled by defining INSTR_FETCH_STALL_CNT_EN.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH      = 128,
  parameter int unsigned ADDR_WIDTH       = 8,
  parameter int unsigned MEM_READ_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  start_addr,
  output logic                   mem_rd_en,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [INSTR_WIDTH-1:0] mem_data,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [7:0]             opcode,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  input  logic [1:0]             instr_ptr_load_en,
  input  logic [ADDR_WIDTH-1:0]  jump_addr,
  input  logic                   alu_cmp,
  input  logic                   done,
  output logic                   busy,
`ifdef INSTR_FETCH_STALL_CNT_EN
  output logic [31:0]            stall_cnt,
`endif
  output logic [ADDR_WIDTH-1:0]  pc
);

  localparam int unsigned CNT_W = $clog2(MEM_READ_LATENCY + 1);

  fetch_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic                   mem_rd_en_q, mem_rd_en_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   valid_q, valid_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  pc_inc;
  logic [ADDR_WIDTH-1:0]  pc_next;

  assign pc_inc = pc_q + ADDR_WIDTH'(1);

  always_comb begin
    pc_next = pc_inc;
    case (iptr_load_e'(instr_ptr_load_en))
      IPTR_JUMP:      pc_next = jump_addr;
      IPTR_JUMP_COND: pc_next = alu_cmp ? jump_addr : pc_inc;
      default:        pc_next = pc_inc;
    endcase
  end

  // The read strobe and address are registered: they are set up on the edge
  // that enters ISSUE, so mem_rd_en is high exactly while the state is ISSUE.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_en_d = 1'b0;
    instr_d     = instr_q;
    valid_d     = valid_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          pc_d        = start_addr;
          mem_addr_d  = start_addr;
          mem_rd_en_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(MEM_READ_LATENCY);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          instr_d = mem_data;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (valid_q && instr_ready) begin
          valid_d = 1'b0;
          if (done) begin
            state_d = IDLE;
          end else begin
            pc_d        = pc_next;
            mem_addr_d  = pc_next;
            mem_rd_en_d = 1'b1;
            state_d     = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      mem_addr_q  <= '0;
      mem_rd_en_q <= 1'b0;
      instr_q     <= '0;
      valid_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_en_q <= mem_rd_en_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef INSTR_FETCH_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && start) begin
      stall_d = '0;
    end else if (state_q != IDLE && !valid_q && stall_q != '1) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

  assign mem_rd_en   = mem_rd_en_q;
  assign mem_addr    = mem_addr_q;
  assign instr_out   = instr_q;
  assign opcode      = instr_q[opcode_msb(INSTR_WIDTH) -: OPCODE_WIDTH];
  assign instr_valid = valid_q;
  assign busy        = (state_q != IDLE);
  assign pc          = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a memory model with latency L, a driver that
// predicts fetch addresses from the pointer-load rules, and a decoupled monitor.
module tb_instr_fetch;

  localparam int L  = 2;
  localparam int IW = 128;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [IW-1:0] mem_data;
  logic [IW-1:0] instr_out;
  logic [7:0]    opcode;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [1:0]    instr_ptr_load_en = '0;
  logic [AW-1:0] jump_addr = '0;
  logic          alu_cmp = 1'b0;
  logic          done = 1'b0;
  logic          busy;
  logic [AW-1:0] pc;
`ifdef INSTR_FETCH_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  instr_fetch #(.INSTR_WIDTH(IW), .ADDR_WIDTH(AW), .MEM_READ_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .instr_out(instr_out), .opcode(opcode), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_ptr_load_en(instr_ptr_load_en),
    .jump_addr(jump_addr), .alu_cmp(alu_cmp), .done(done), .busy(busy),
`ifdef INSTR_FETCH_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .pc(pc)
  );

  always #5 clk = ~clk;

  // Memory model: data for a strobe in cycle s is visible in cycle s+L;
  // otherwise the bus carries random garbage.
  logic [IW-1:0] mem [0:255];
  logic [IW-1:0] pipe_d [L];
  logic          pipe_v [L];
  logic [IW-1:0] garbage;
  int            cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    garbage <= {$urandom, $urandom, $urandom, $urandom};
    pipe_d[0] <= mem[mem_addr];
    pipe_v[0] <= mem_rd_en;
    for (int i = 1; i < L; i++) begin
      pipe_d[i] <= pipe_d[i-1];
      pipe_v[i] <= pipe_v[i-1];
    end
  end
  assign mem_data = pipe_v[L-1] ? pipe_d[L-1] : garbage;

  int tests = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [IW-1:0] act, input logic [IW-1:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard state shared between driver and monitor.
  int exp_addr [$];
  int exp_instr [$];
  int rd_due_cyc = -1;
  int done_due_cyc = -1;
  int model_pc = 0;

  function automatic int model_next(input int cur, input int ld, input int ja, input bit cmp);
    int inc;
    inc = (cur + 1) % 256;
    if (ld == 1) return ja;
    if (ld == 2) return cmp ? ja : inc;
    return inc;
  endfunction

  // Monitor
  initial begin
    logic [IW-1:0] held, expd;
    logic [7:0]    exp_op;
    logic [AW-1:0] held_pc;
    bit prev_v, prev_rdy;
    int a, rd_cyc;
    prev_v = 0; prev_rdy = 0; rd_cyc = 0; held = '0; held_pc = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 0;
        prev_rdy = 0;
      end else begin
        if (cyc == rd_due_cyc) chk("rd_follows_start_or_accept", IW'(mem_rd_en), IW'(1));
        if (cyc == done_due_cyc) begin
          chk("done_busy", IW'(busy), '0);
          chk("done_no_rd", IW'(mem_rd_en), '0);
        end
        if (mem_rd_en) begin
          if (exp_addr.size() == 0) begin
            chk("unexpected_rd", IW'(mem_rd_en), '0);
          end else begin
            a = exp_addr.pop_front();
            chk("mem_addr", IW'(mem_addr), IW'(a));
            exp_instr.push_back(a);
            rd_cyc = cyc;
          end
        end
        if (instr_valid) begin
          if (prev_v && !prev_rdy) begin
            chk("hold_stable", instr_out, held);
            chk("hold_pc", IW'(pc), IW'(held_pc));
          end else if (exp_instr.size() == 0) begin
            chk("unexpected_valid", IW'(instr_valid), '0);
          end else begin
            a = exp_instr.pop_front();
            expd = mem[a];
            exp_op = expd[IW-1 -: 8];
            chk("instr_out", instr_out, expd);
            chk("opcode", IW'(opcode), IW'(exp_op));
            chk("pc", IW'(pc), IW'(a));
            chk("valid_latency", IW'(cyc - rd_cyc), IW'(L + 1));
          end
        end
        held = instr_out;
        held_pc = pc;
        prev_v = instr_valid;
        prev_rdy = instr_ready;
      end
    end
  end

  // Driver tasks run in the phase #1 after a rising edge.
  task automatic do_start(input logic [AW-1:0] a);
    start = 1'b1;
    start_addr = a;
    @(posedge clk); #1;
    start = 1'b0;
    start_addr = $urandom;
    model_pc = int'(a);
    exp_addr.push_back(int'(a));
    rd_due_cyc = cyc;
  endtask

  task automatic do_instr(input int stall, input logic [1:0] ld, input logic [AW-1:0] ja,
                          input logic cmp, input logic dn);
    int n;
    instr_ptr_load_en = ld;
    jump_addr = ja;
    alu_cmp = cmp;
    done = dn;
    instr_ready = (stall == 0);
    n = 0;
    while (!instr_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!instr_valid) begin
      chk("valid_timeout", IW'(instr_valid), IW'(1));
      instr_ready = 1'b0;
      done = 1'b0;
      return;
    end
    repeat (stall) begin @(posedge clk); #1; end
    instr_ready = 1'b1;
    @(posedge clk); #1;
    instr_ready = 1'b0;
    if (dn) begin
      done_due_cyc = cyc;
    end else begin
      model_pc = model_next(model_pc, int'(ld), int'(ja), cmp);
      exp_addr.push_back(model_pc);
      rd_due_cyc = cyc;
    end
    done = 1'b0;
    instr_ptr_load_en = 2'($urandom);
    jump_addr = $urandom;
    alu_cmp = 1'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < L; i++) begin pipe_v[i] = 1'b0; pipe_d[i] = '0; end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc", IW'(pc), '0);
    chk("rst_mem_addr", IW'(mem_addr), '0);
    chk("rst_instr_out", instr_out, '0);
    chk("rst_mem_rd_en", IW'(mem_rd_en), '0);
    chk("rst_instr_valid", IW'(instr_valid), '0);
    chk("rst_busy", IW'(busy), '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Sequential run with ready effectively always high
    do_start(8'h10);
`ifdef INSTR_FETCH_STALL_CNT_EN
    chk("stall_cnt_cleared_first", IW'(stall_cnt), '0);
`endif
    do_instr(0, 2'b00, 8'h00, 1'b0, 1'b0);
    do_instr(0, 2'b00, 8'h00, 1'b0, 1'b0);
    do_instr(0, 2'b00, 8'h00, 1'b0, 1'b1);
`ifdef INSTR_FETCH_STALL_CNT_EN
    chk("stall_cnt_three", IW'(stall_cnt), IW'(3 * (L + 1)));
`endif

    // Backpressure, plus a start pulse while busy that must be ignored
    do_start(8'h20);
`ifdef INSTR_FETCH_STALL_CNT_EN
    chk("stall_cnt_cleared_by_start", IW'(stall_cnt), '0);
`endif
    start = 1'b1; start_addr = 8'h99;
    @(posedge clk); #1;
    start = 1'b0;
    do_instr(5, 2'b00, 8'h00, 1'b0, 1'b0);
    do_instr(0, 2'b00, 8'h00, 1'b0, 1'b1);

    // Jumps
    do_start(8'h50);
    do_instr(0, 2'b01, 8'h40, 1'b0, 1'b0);
    do_instr(1, 2'b10, 8'h40, 1'b1, 1'b0);
    do_instr(0, 2'b10, 8'h40, 1'b0, 1'b0);
    do_instr(2, 2'b11, 8'h40, 1'b0, 1'b0);
    do_instr(0, 2'b00, 8'h00, 1'b0, 1'b1);

    // Wrap, then done together with a jump
    do_start(8'hFF);
    do_instr(0, 2'b00, 8'h00, 1'b0, 1'b0);
    do_instr(0, 2'b01, 8'h40, 1'b0, 1'b1);
    repeat (6) begin @(posedge clk); #1; end

    // Reset while waiting for read data
    do_start(8'h60);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_pc", IW'(pc), '0);
    chk("midrst_mem_addr", IW'(mem_addr), '0);
    chk("midrst_instr_out", instr_out, '0);
    chk("midrst_mem_rd_en", IW'(mem_rd_en), '0);
    chk("midrst_valid", IW'(instr_valid), '0);
    chk("midrst_busy", IW'(busy), '0);
    exp_addr.delete();
    exp_instr.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) begin
      chk("post_rst_no_valid", IW'(instr_valid), '0);
      @(posedge clk); #1;
    end
    do_start(8'h70);
    do_instr(0, 2'b00, 8'h00, 1'b0, 1'b0);
    do_instr(0, 2'b00, 8'h00, 1'b0, 1'b1);

    // Randomised traffic
    do_start(8'($urandom));
    for (int i = 0; i < 60; i++) begin
      logic dn;
      dn = ($urandom_range(0, 7) == 0);
      do_instr($urandom_range(0, 3), 2'($urandom), 8'($urandom), 1'($urandom), dn);
      if (dn) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        do_start(8'($urandom));
      end
    end
    do_instr(0, 2'b00, 8'h00, 1'b0, 1'b1);
    repeat (6) begin @(posedge clk); #1; end

    chk("scoreboard_addr_drained", IW'(exp_addr.size()), '0);
    chk("scoreboard_instr_drained", IW'(exp_instr.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
